// File: rtl/inst_buffer_queue_if.sv
// Handshake bundle between decode, the instruction buffer and rename.
// The buffer side uses the slave modport; the decode/rename side uses master.
interface inst_buffer_queue_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 4,
    parameter int DEPTH     = 32,
    parameter int DATA_W    = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // decode -> buffer
    logic                               decode_ready;
    logic [IN_WIDTH-1:0]                ib_valid;
    logic [IN_WIDTH-1:0][DATA_W-1:0]    ib_data;
    // pipeline control
    logic                               flush;
    logic                               stall;
    // buffer -> rename
    logic [OUT_WIDTH-1:0]               ren_valid;
    logic [OUT_WIDTH-1:0][DATA_W-1:0]   ren_data;
    logic                               inst_buffer_ready;
    logic                               inst_buffer_full;
    logic [CNT_W-1:0]                   inst_count;

    modport master (
        output decode_ready, ib_valid, ib_data, flush, stall,
        input  ren_valid, ren_data, inst_buffer_ready, inst_buffer_full, inst_count
    );

    modport slave (
        input  decode_ready, ib_valid, ib_data, flush, stall,
        output ren_valid, ren_data, inst_buffer_ready, inst_buffer_full, inst_count
    );
endinterface

// File: rtl/inst_buffer_queue.sv
// Instruction buffer: compacts up to IN_WIDTH valid decoded packets per cycle
// into a circular queue and hands fixed groups of OUT_WIDTH to rename.
// DEPTH must be a power of two and at least IN_WIDTH + OUT_WIDTH.
module inst_buffer_queue #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 4,
    parameter int DEPTH     = 32,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    inst_buffer_queue_if.slave  ib
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] IN_C    = CNT_W'(IN_WIDTH);
    localparam logic [CNT_W-1:0] OUT_C   = CNT_W'(OUT_WIDTH);
    localparam logic [PTR_W-1:0] OUT_P   = PTR_W'(OUT_WIDTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [PTR_W-1:0] wr_addr [IN_WIDTH];
    logic [CNT_W-1:0] n_wr;
    logic [CNT_W-1:0] free_slots;
    logic             full;
    logic             ready;
    logic             wr_en;
    logic             rd_en;

    // Status is derived from the registered count only, so no input reaches
    // these outputs combinationally (full ignores a same-cycle read).
    assign free_slots = DEPTH_C - count_reg;
    assign full       = free_slots < IN_C;
    assign ready      = count_reg >= OUT_C;

    assign wr_en = ib.decode_ready & ~full & ~ib.flush;
    assign rd_en = ready & ~ib.stall & ~ib.flush;

    assign ib.inst_buffer_ready = ready;
    assign ib.inst_buffer_full  = full;
    assign ib.inst_count        = count_reg;

    // Compaction: each valid lane lands at tail + (number of valid lanes below it).
    always_comb begin
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < IN_WIDTH; k++) begin
            wr_addr[k] = tail_reg + acc[PTR_W-1:0];
            acc        = acc + CNT_W'(ib.ib_valid[k]);
        end
        n_wr = acc;
    end

    // Entry array write; contents are never reset, pointers define validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < IN_WIDTH; k++) begin
            if (wr_en && ib.ib_valid[k]) begin
                mem[wr_addr[k]] <= ib.ib_data[k];
            end
        end
    end

    // Read port: oldest OUT_WIDTH entries, head first; a group is only
    // flagged valid when all of it is present.
    generate
        for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_read
            logic [PTR_W-1:0] rd_addr;
            assign rd_addr        = head_reg + PTR_W'(gi);
            assign ib.ren_data[gi]  = mem[rd_addr];
            assign ib.ren_valid[gi] = ready;
        end
    endgenerate

    // Next-state for pointers and occupancy; flush wins over read and write.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (ib.flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (wr_en) begin
                tail_next = tail_reg + n_wr[PTR_W-1:0];
            end
            if (rd_en) begin
                head_next = head_reg + OUT_P;
            end
            count_next = count_reg + (wr_en ? n_wr : '0) - (rd_en ? OUT_C : '0);
        end
    end

    // Pointer/occupancy registers; reset empties the queue immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end
endmodule

// File: tb/tb_inst_buffer_queue.sv
// Directed testbench for inst_buffer_queue (IN_WIDTH=8, OUT_WIDTH=4, DEPTH=32).
module tb_inst_buffer_queue;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    inst_buffer_queue_if #(.IN_WIDTH(8), .OUT_WIDTH(4), .DEPTH(32), .DATA_W(32)) ibq ();

    inst_buffer_queue #(.IN_WIDTH(8), .OUT_WIDTH(4), .DEPTH(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ib      (ibq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] grp(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] mask, input logic [7:0] base);
        ibq.decode_ready = 1'b1;
        ibq.ib_valid     = mask;
        for (int k = 0; k < 8; k++) begin
            ibq.ib_data[k] = {24'h0, base + 8'(k)};
        end
        $display("bundle mask=%b base=%h stall=%0b flush=%0b", mask, base, ibq.stall, ibq.flush);
    endtask

    task automatic idle();
        ibq.decode_ready = 1'b0;
        ibq.ib_valid     = '0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (ibq.inst_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ibq.inst_count); end
        checks++; if (ibq.inst_buffer_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ibq.inst_buffer_ready); end
        checks++; if (ibq.inst_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", ibq.inst_buffer_full); end
        checks++; if (ibq.ren_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %h exp 0", ibq.ren_valid); end
        #5 reset_n = 1'b1;
        // load 12 entries, then reset mid-cycle
        ibq.stall = 1'b1;
        step(); drive(8'hFF, 8'h00);
        step(); drive(8'h0F, 8'h10);
        step(); idle();
        checks++; if (ibq.inst_count !== 6'd12) begin errors++; $display("FAIL preload_count got %0d exp 12", ibq.inst_count); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (ibq.inst_count !== 6'd0) begin errors++; $display("FAIL async_count got %0d exp 0", ibq.inst_count); end
        checks++; if (ibq.inst_buffer_ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b exp 0", ibq.inst_buffer_ready); end
        checks++; if (ibq.ren_valid !== 4'h0) begin errors++; $display("FAIL async_valid got %h exp 0", ibq.ren_valid); end
        #1 reset_n = 1'b1;
        drive(8'h07, 8'h20);
        step();
        checks++; if (ibq.inst_buffer_ready !== 1'b0) begin errors++; $display("FAIL post_reset_3_ready got %b exp 0", ibq.inst_buffer_ready); end
        checks++; if (ibq.inst_count !== 6'd3) begin errors++; $display("FAIL post_reset_3_count got %0d exp 3", ibq.inst_count); end
        drive(8'h01, 8'h30);
        step();
        checks++; if (ibq.inst_buffer_ready !== 1'b1) begin errors++; $display("FAIL post_reset_4_ready got %b exp 1", ibq.inst_buffer_ready); end
        checks++; if (ibq.ren_data !== grp(32'h20, 32'h21, 32'h22, 32'h30)) begin errors++; $display("FAIL post_reset_group got %h exp %h", ibq.ren_data, grp(32'h20, 32'h21, 32'h22, 32'h30)); end
        idle(); ibq.stall = 1'b0;
        step();
        checks++; if (ibq.inst_count !== 6'd0) begin errors++; $display("FAIL post_reset_drain got %0d exp 0", ibq.inst_count); end
    endtask

    task automatic test_compaction();
        ibq.stall = 1'b0;
        drive(8'b0101_1010, 8'hA0);
        step(); idle();
        checks++; if (ibq.inst_buffer_ready !== 1'b1) begin errors++; $display("FAIL compact_ready got %b exp 1", ibq.inst_buffer_ready); end
        checks++; if (ibq.ren_valid !== 4'hF) begin errors++; $display("FAIL compact_valid got %h exp f", ibq.ren_valid); end
        checks++; if (ibq.inst_count !== 6'd4) begin errors++; $display("FAIL compact_count got %0d exp 4", ibq.inst_count); end
        checks++; if (ibq.ren_data !== grp(32'hA1, 32'hA3, 32'hA4, 32'hA6)) begin errors++; $display("FAIL compact_group got %h exp %h", ibq.ren_data, grp(32'hA1, 32'hA3, 32'hA4, 32'hA6)); end
        step();
        checks++; if (ibq.inst_count !== 6'd0) begin errors++; $display("FAIL compact_drain got %0d exp 0", ibq.inst_count); end
        checks++; if (ibq.inst_buffer_ready !== 1'b0) begin errors++; $display("FAIL compact_drain_ready got %b exp 0", ibq.inst_buffer_ready); end
    endtask

    task automatic test_partial();
        ibq.stall = 1'b0;
        drive(8'h07, 8'h10);
        step();
        checks++; if (ibq.inst_buffer_ready !== 1'b0) begin errors++; $display("FAIL partial_ready got %b exp 0", ibq.inst_buffer_ready); end
        checks++; if (ibq.inst_count !== 6'd3) begin errors++; $display("FAIL partial_count got %0d exp 3", ibq.inst_count); end
        drive(8'h81, 8'h20);
        step(); idle();
        checks++; if (ibq.inst_count !== 6'd5) begin errors++; $display("FAIL partial5_count got %0d exp 5", ibq.inst_count); end
        checks++; if (ibq.ren_data !== grp(32'h10, 32'h11, 32'h12, 32'h20)) begin errors++; $display("FAIL partial_group got %h exp %h", ibq.ren_data, grp(32'h10, 32'h11, 32'h12, 32'h20)); end
        step();
        checks++; if (ibq.inst_count !== 6'd1) begin errors++; $display("FAIL partial_remain got %0d exp 1", ibq.inst_count); end
        checks++; if (ibq.inst_buffer_ready !== 1'b0) begin errors++; $display("FAIL partial_remain_ready got %b exp 0", ibq.inst_buffer_ready); end
        ibq.flush = 1'b1; step(); ibq.flush = 1'b0;
    endtask

    task automatic test_full();
        ibq.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(8'hFF, 8'(8 * i));
            step();
            if (i == 2) begin
                checks++; if (ibq.inst_count !== 6'd24) begin errors++; $display("FAIL full3_count got %0d exp 24", ibq.inst_count); end
                checks++; if (ibq.inst_buffer_full !== 1'b0) begin errors++; $display("FAIL full3_flag got %b exp 0", ibq.inst_buffer_full); end
            end
        end
        checks++; if (ibq.inst_count !== 6'd32) begin errors++; $display("FAIL full4_count got %0d exp 32", ibq.inst_count); end
        checks++; if (ibq.inst_buffer_full !== 1'b1) begin errors++; $display("FAIL full4_flag got %b exp 1", ibq.inst_buffer_full); end
        drive(8'hFF, 8'hE0);
        step(); idle();
        checks++; if (ibq.inst_count !== 6'd32) begin errors++; $display("FAIL full_drop_count got %0d exp 32", ibq.inst_count); end
        checks++; if (ibq.ren_data !== grp(32'h00, 32'h01, 32'h02, 32'h03)) begin errors++; $display("FAIL full_drop_group got %h exp %h", ibq.ren_data, grp(32'h00, 32'h01, 32'h02, 32'h03)); end
        ibq.flush = 1'b1; step(); ibq.flush = 1'b0;
    endtask

    // Fill to tail=30, drain to head=24, then write 8 (tail wraps to 6)
    // while reading; later groups read across the 31->0 boundary.
    task automatic test_wrap();
        ibq.stall = 1'b1;
        drive(8'hFF, 8'h00); step();
        drive(8'hFF, 8'h08); step();
        drive(8'hFF, 8'h10); step();
        drive(8'h3F, 8'h18); step(); idle();
        checks++; if (ibq.inst_count !== 6'd30) begin errors++; $display("FAIL wrap_fill got %0d exp 30", ibq.inst_count); end
        checks++; if (ibq.inst_buffer_full !== 1'b1) begin errors++; $display("FAIL wrap_fill_full got %b exp 1", ibq.inst_buffer_full); end
        ibq.stall = 1'b0;
        repeat (6) step();
        checks++; if (ibq.inst_count !== 6'd6) begin errors++; $display("FAIL wrap_drain got %0d exp 6", ibq.inst_count); end
        checks++; if (ibq.ren_data !== grp(32'h18, 32'h19, 32'h1A, 32'h1B)) begin errors++; $display("FAIL wrap_group24 got %h exp %h", ibq.ren_data, grp(32'h18, 32'h19, 32'h1A, 32'h1B)); end
        drive(8'hFF, 8'h40);
        step(); idle();
        checks++; if (ibq.inst_count !== 6'd10) begin errors++; $display("FAIL wrap_rw_count got %0d exp 10", ibq.inst_count); end
        checks++; if (ibq.ren_data !== grp(32'h1C, 32'h1D, 32'h40, 32'h41)) begin errors++; $display("FAIL wrap_group28 got %h exp %h", ibq.ren_data, grp(32'h1C, 32'h1D, 32'h40, 32'h41)); end
        step();
        checks++; if (ibq.inst_count !== 6'd6) begin errors++; $display("FAIL wrap_count6 got %0d exp 6", ibq.inst_count); end
        checks++; if (ibq.ren_data !== grp(32'h42, 32'h43, 32'h44, 32'h45)) begin errors++; $display("FAIL wrap_group0 got %h exp %h", ibq.ren_data, grp(32'h42, 32'h43, 32'h44, 32'h45)); end
        step();
        checks++; if (ibq.inst_count !== 6'd2) begin errors++; $display("FAIL wrap_count2 got %0d exp 2", ibq.inst_count); end
        checks++; if (ibq.ren_valid !== 4'h0) begin errors++; $display("FAIL wrap_tail_valid got %h exp 0", ibq.ren_valid); end
        ibq.flush = 1'b1; step(); ibq.flush = 1'b0;
    endtask

    task automatic test_flush();
        ibq.stall = 1'b1;
        drive(8'hFF, 8'h50);
        step();
        checks++; if (ibq.inst_count !== 6'd8) begin errors++; $display("FAIL flush_pre got %0d exp 8", ibq.inst_count); end
        ibq.stall = 1'b0;
        ibq.flush = 1'b1;
        drive(8'hFF, 8'h60);
        step();
        checks++; if (ibq.inst_count !== 6'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", ibq.inst_count); end
        checks++; if (ibq.inst_buffer_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", ibq.inst_buffer_ready); end
        checks++; if (ibq.inst_buffer_full !== 1'b0) begin errors++; $display("FAIL flush_full got %b exp 0", ibq.inst_buffer_full); end
        ibq.flush = 1'b0;
        ibq.stall = 1'b1;
        drive(8'h0F, 8'h70);
        step(); idle();
        checks++; if (ibq.inst_count !== 6'd4) begin errors++; $display("FAIL flush_after_count got %0d exp 4", ibq.inst_count); end
        checks++; if (ibq.ren_data !== grp(32'h70, 32'h71, 32'h72, 32'h73)) begin errors++; $display("FAIL flush_after_group got %h exp %h", ibq.ren_data, grp(32'h70, 32'h71, 32'h72, 32'h73)); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        ibq.decode_ready = 1'b0;
        ibq.ib_valid = '0;
        ibq.ib_data = '0;
        ibq.flush = 1'b0;
        ibq.stall = 1'b0;
        test_reset();
        test_compaction();
        test_partial();
        test_full();
        test_wrap();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
